// File: rtl/dmem_responder.sv
// Data-memory responder: services Memory-stage loads/stores against an internal
// word RAM after a fixed number of wait states, with a registered response.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqM,
  input  logic        MemWriteM,
  input  logic        MByteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemErr,
  output logic        MemStall
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;

  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic          byte_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          mis;
  logic          acc;
  logic [31:0]   rd_word;
  logic          unused_addr;

  function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] l);
    return w[{l, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] merge_byte(input logic [31:0] w, input logic [7:0] b,
                                             input logic [1:0] l);
    logic [31:0] r;
    r = w;
    r[{l, 3'b000} +: 8] = b;
    return r;
  endfunction

  // Address bits above the RAM span are deliberately dropped so accesses wrap.
  assign unused_addr = ^ALUOutM[31:AW+2];

  assign idx     = addr_q[AW+1:2];
  assign lane    = addr_q[1:0];
  assign mis     = !byte_q && (addr_q[1:0] != 2'b00);
  assign acc     = (state_q == WAIT) && (cnt_q == 4'd0);
  assign rd_word = mem[idx];

  always_ff @(posedge clk) begin
    if (state_q == IDLE && ReqM) begin
      addr_q  <= ALUOutM[AW+1:0];
      wdata_q <= WriteDataM;
      we_q    <= MemWriteM;
      byte_q  <= MByteM;
    end
  end

  // Misaligned stores are suppressed; byte stores read-modify-write one lane.
  always_ff @(posedge clk) begin
    if (acc && we_q && !mis) begin
      mem[idx] <= byte_q ? merge_byte(rd_word, wdata_q[7:0], lane) : wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ReqM) begin
          state_d = WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          ready_d = 1'b1;
          err_d   = mis;
          if (!we_q) begin
            if (mis)         rdata_d = 32'd0;
            else if (byte_q) rdata_d = {24'd0, lane_sel(rd_word, lane)};
            else             rdata_d = rd_word;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign ReadData = rdata_q;
  assign MemReady = ready_q;
  assign MemErr   = err_q;
  assign MemStall = ((state_q == IDLE) && ReqM) || (state_q == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset corner cases, and
// randomized accesses checked against a simple memory model.
module tb_dmem_responder;

  localparam int W     = 2;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        ReqM;
  logic        MemWriteM;
  logic        MByteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemErr;
  logic        MemStall;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] rd_m;

  typedef struct {
    logic        we;
    logic        bt;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [15];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .ReqM      (ReqM),
    .MemWriteM (MemWriteM),
    .MByteM    (MByteM),
    .ALUOutM   (ALUOutM),
    .WriteDataM(WriteDataM),
    .ReadData  (ReadData),
    .MemReady  (MemReady),
    .MemErr    (MemErr),
    .MemStall  (MemStall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Reference behaviour: word array plus last load result.
  task automatic model(input logic we, input logic bt, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] erd, output logic eerr);
    int idx;
    int lane;
    logic [31:0] w;
    idx  = int'((addr >> 2) % DEPTH);
    lane = int'(addr[1:0]);
    w    = mem_m[idx];
    eerr = !bt && (addr[1:0] != 2'b00);
    if (we) begin
      if (!eerr) begin
        if (bt) w[lane*8 +: 8] = wd[7:0];
        else    w = wd;
        mem_m[idx] = w;
      end
    end else begin
      if (eerr)    rd_m = 32'd0;
      else if (bt) rd_m = (w >> (lane*8)) & 32'hFF;
      else         rd_m = w;
    end
    erd = rd_m;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after DONE.
  task automatic access(input logic we, input logic bt, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input bit scr, input string tag);
    bit got;
    got        = 1'b0;
    ReqM       = 1'b1;
    MemWriteM  = we;
    MByteM     = bt;
    ALUOutM    = addr;
    WriteDataM = wd;
    #1 chk({tag, "_stall_req"}, 32'(MemStall), 32'd1);
    for (int k = 1; k <= W + 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (MemReady) begin
        got = 1'b1;
        chk({tag, "_latency"}, 32'(k), 32'(W + 2));
        chk({tag, "_stall_ready"}, 32'(MemStall), 32'd0);
        chk({tag, "_err"}, 32'(MemErr), 32'(exp_err));
        chk({tag, "_rdata"}, ReadData, exp_rd);
        ReqM = 1'b0;
        break;
      end
      chk({tag, "_stall_wait"}, 32'(MemStall), 32'd1);
      if (scr) begin
        ReqM       = 1'($urandom_range(0, 1));
        MemWriteM  = 1'($urandom_range(0, 1));
        MByteM     = 1'($urandom_range(0, 1));
        ALUOutM    = $urandom;
        WriteDataM = $urandom;
      end else begin
        ReqM = 1'b0;
      end
    end
    if (!got) begin
      tot_cnt++;
      $display("FAIL %s_timeout actual=no_ready required=ready_within_%0d", tag, W + 2);
    end
    ReqM = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_ready_clear"}, 32'(MemReady), 32'd0);
    chk({tag, "_err_clear"}, 32'(MemErr), 32'd0);
    chk({tag, "_stall_idle"}, 32'(MemStall), 32'd0);
  endtask

  initial begin
    logic [31:0] erd;
    logic        eerr;
    logic [31:0] old40;

    tbl[0]  = '{1'b1, 1'b0, 32'h030, 32'h600DF00D, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h010, 32'h00000000, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h020, 32'h11223344, 32'hDEADBEEF, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 32'h022, 32'h000000AA, 32'hDEADBEEF, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 32'h020, 32'h00000000, 32'h11AA3344, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h023, 32'h00000000, 32'h00000011, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h031, 32'h00000055, 32'h00000011, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 32'h030, 32'h00000000, 32'h600DF00D, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h033, 32'h00000000, 32'h00000000, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 32'h100, 32'hCAFEF00D, 32'h00000000, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 32'h000, 32'h00000000, 32'hCAFEF00D, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 32'h101, 32'h00000000, 32'h000000F0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 32'h003, 32'hFFFFFF7E, 32'h000000F0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 32'h000, 32'h00000000, 32'h7EFEF00D, 1'b0};

    reset = 1'b1; ReqM = 1'b0; MemWriteM = 1'b0; MByteM = 1'b0;
    ALUOutM = 32'd0; WriteDataM = 32'd0; rd_m = 32'd0;
    #2;
    chk("rst_rdata", ReadData, 32'd0);
    chk("rst_ready", 32'(MemReady), 32'd0);
    chk("rst_err", 32'(MemErr), 32'd0);
    chk("rst_stall_lo", 32'(MemStall), 32'd0);
    ReqM = 1'b1;
    #1 chk("rst_stall_hi", 32'(MemStall), 32'd1);
    ReqM = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] wd;
      wd = $urandom;
      model(1'b1, 1'b0, 32'(i * 4), wd, erd, eerr);
      access(1'b1, 1'b0, 32'(i * 4), wd, erd, eerr, 1'b0, "init");
    end

    for (int i = 0; i < 15; i++) begin
      model(tbl[i].we, tbl[i].bt, tbl[i].addr, tbl[i].wd, erd, eerr);
      access(tbl[i].we, tbl[i].bt, tbl[i].addr, tbl[i].wd, tbl[i].exp_rd,
             tbl[i].exp_err, 1'b1, $sformatf("vec%0d", i));
    end

    // Reset during the WAIT of a store: store dropped, response cleared.
    old40      = mem_m[16];
    ReqM       = 1'b1;
    MemWriteM  = 1'b1;
    MByteM     = 1'b0;
    ALUOutM    = 32'h40;
    WriteDataM = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    ReqM = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_ready", 32'(MemReady), 32'd0);
    chk("midrst_rdata", ReadData, 32'd0);
    chk("midrst_stall", 32'(MemStall), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_ready_hold", 32'(MemReady), 32'd0);
    end
    reset = 1'b0;
    rd_m  = 32'd0;
    model(1'b0, 1'b0, 32'h40, 32'd0, erd, eerr);
    access(1'b0, 1'b0, 32'h40, 32'd0, old40, 1'b0, 1'b0, "midrst_load");

    for (int i = 0; i < 40; i++) begin
      logic        we;
      logic        bt;
      logic [31:0] addr;
      logic [31:0] wd;
      we   = 1'($urandom_range(0, 1));
      bt   = 1'($urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      wd   = $urandom;
      model(we, bt, addr, wd, erd, eerr);
      access(we, bt, addr, wd, erd, eerr, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
